// File: rtl/eth_idma_pkg.sv
// AXI-Stream request/response types, default frame limit and FSM state
// encoding shared by the Ethernet TX frame mux and its testbench.
package eth_idma_pkg;

    localparam int unsigned DataWidth       = 64;
    localparam int unsigned StrbWidth       = DataWidth / 8;
    localparam int unsigned IdWidth         = 4;
    localparam int unsigned DestWidth       = 4;
    localparam int unsigned UserWidth       = 1;
    // 1518 B at 8 B per beat, rounded up.
    localparam int unsigned DefaultMaxBeats = 190;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic [StrbWidth-1:0] keep;
        logic                 last;
        logic [IdWidth-1:0]   id;
        logic [DestWidth-1:0] dest;
        logic [UserWidth-1:0] user;
    } axis_t_chan_t;

    typedef struct packed {
        axis_t_chan_t t;
        logic         tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DRAIN
    } mux_state_e;

endpackage

// File: rtl/eth_axis_rr_sel.sv
// Rotating-priority selector: returns the first set request at or after
// rr_ptr_i, wrapping modulo NumChan.
module eth_axis_rr_sel #(
    parameter  int unsigned NumChan = 2,
    localparam int unsigned IdxW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic [NumChan-1:0] req_i,
    input  logic [IdxW-1:0]    rr_ptr_i,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               gnt_vld_o
);

    int unsigned idx;

    // NOTE: every signal written here gets a value before any branch, otherwise a latch is inferred.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NumChan; k++) begin
            idx = (32'(rr_ptr_i) + k) % NumChan;
            if (!gnt_vld_o && req_i[idx[IdxW-1:0]]) begin
                gnt_idx_o = idx[IdxW-1:0];
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_axis_tx_frame_mux.sv
// Frame-atomic N:1 AXI-Stream mux feeding the MAC TX port: round-robin at
// frame granularity, per-channel enable, oversize truncation and frame counters.
module eth_axis_tx_frame_mux #(
    parameter  int unsigned NumChan    = 2,
    parameter  int unsigned MaxBeats   = eth_idma_pkg::DefaultMaxBeats,
    parameter  int unsigned CntWidth   = 16,
    parameter  type         axis_req_t = eth_idma_pkg::axis_req_t,
    parameter  type         axis_rsp_t = eth_idma_pkg::axis_rsp_t,
    localparam int unsigned GntWidth   = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumChan-1:0]                chan_en_i,
    input  axis_req_t                         s_axis_req_i [NumChan],
    output axis_rsp_t                         s_axis_rsp_o [NumChan],
    output axis_req_t                         m_axis_req_o,
    input  axis_rsp_t                         m_axis_rsp_i,
    output logic [GntWidth-1:0]               grant_o,
    output logic                              busy_o,
    output logic                              oversize_o,
    output logic [NumChan-1:0][CntWidth-1:0]  frame_cnt_o
);

    import eth_idma_pkg::*;

    localparam int unsigned         BeatWidth = $clog2(MaxBeats + 1);
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(MaxBeats - 1);
    localparam logic [GntWidth-1:0]  LastChan = GntWidth'(NumChan - 1);

    mux_state_e                   state_q, state_d;
    logic [GntWidth-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GntWidth-1:0]          grant_q, grant_d;
    logic [BeatWidth-1:0]         beat_cnt_q, beat_cnt_d;
    logic [NumChan-1:0][CntWidth-1:0] frame_cnt_q, frame_cnt_d;
    logic                         oversize_q, oversize_d;

    logic [NumChan-1:0]           cand;
    logic [GntWidth-1:0]          sel_idx;
    logic                         sel_vld;
    logic [GntWidth-1:0]          grant_nxt;
    axis_req_t                    gnt_req;

    always_comb begin
        for (int unsigned i = 0; i < NumChan; i++) begin
            cand[i] = s_axis_req_i[i].tvalid & chan_en_i[i];
        end
    end

    eth_axis_rr_sel #(
        .NumChan (NumChan)
    ) i_rr_sel (
        .req_i     (cand),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_idx_o (sel_idx),
        .gnt_vld_o (sel_vld)
    );

    assign gnt_req   = s_axis_req_i[grant_q];
    assign grant_nxt = (grant_q == LastChan) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        oversize_d  = 1'b0;
        m_axis_req_o = '0;
        for (int unsigned i = 0; i < NumChan; i++) begin
            s_axis_rsp_o[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d    = sel_idx;
                    beat_cnt_d = '0;
                    state_d    = FWD;
                end
            end
            FWD: begin
                m_axis_req_o                 = gnt_req;
                s_axis_rsp_o[grant_q].tready = m_axis_rsp_i.tready;
                // The last permitted beat closes the frame towards the MAC and flags it as aborted.
                if (beat_cnt_q == LastBeat && !gnt_req.t.last) begin
                    m_axis_req_o.t.last = 1'b1;
                    m_axis_req_o.t.user = 1'b1;
                end
                if (gnt_req.tvalid && m_axis_rsp_i.tready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (gnt_req.t.last) begin
                        frame_cnt_d[grant_q] = frame_cnt_q[grant_q] + 1'b1;
                        rr_ptr_d             = grant_nxt;
                        state_d              = IDLE;
                    end else if (beat_cnt_q == LastBeat) begin
                        frame_cnt_d[grant_q] = frame_cnt_q[grant_q] + 1'b1;
                        oversize_d           = 1'b1;
                        state_d              = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_axis_rsp_o[grant_q].tready = 1'b1;
                if (gnt_req.tvalid && gnt_req.t.last) begin
                    rr_ptr_d = grant_nxt;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only; sequential state uses non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            oversize_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            oversize_q  <= oversize_d;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign oversize_o  = oversize_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_eth_axis_tx_frame_mux.sv
// Randomized bench for the TX frame mux: per-channel frame queues feed the DUT,
// a frame-level arbitration model predicts the MAC-side beat stream.
module tb_eth_axis_tx_frame_mux;
    import eth_idma_pkg::*;

    localparam int unsigned NCH  = 2;
    localparam int unsigned MAXB = 8;
    localparam int unsigned CW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NCH-1:0]           chan_en;
    axis_req_t                s_req [NCH];
    axis_rsp_t                s_rsp [NCH];
    axis_req_t                m_req;
    axis_rsp_t                m_rsp;
    logic [0:0]               grant;
    logic                     busy;
    logic                     ovs;
    logic [NCH-1:0][CW-1:0]   fcnt;

    eth_axis_tx_frame_mux #(
        .NumChan  (NCH),
        .MaxBeats (MAXB),
        .CntWidth (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .chan_en_i    (chan_en),
        .s_axis_req_i (s_req),
        .s_axis_rsp_o (s_rsp),
        .m_axis_req_o (m_req),
        .m_axis_rsp_i (m_rsp),
        .grant_o      (grant),
        .busy_o       (busy),
        .oversize_o   (ovs),
        .frame_cnt_o  (fcnt)
    );

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef logic [63:0] dq_t [$];
    typedef bit          bq_t [$];
    typedef int          lq_t [$];

    // Driver side: raw beats still to be offered by each channel.
    dq_t drv_data [NCH];
    bq_t drv_last [NCH];
    bit  mid [NCH];
    // Model side: the same frames, consumed as whole frames by the arbiter model.
    dq_t mdl_data [NCH];
    lq_t mdl_len  [NCH];
    int  mdl_rr;
    int  exp_cnt [NCH];
    int  exp_trunc;
    beat_t exp_q [$];
    beat_t got_q [$];

    int vectors = 0;
    int errors  = 0;

    task automatic load_frame(input int ch, input int len);
        logic [63:0] d;
        for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            drv_data[ch].push_back(d);
            drv_last[ch].push_back(b == len - 1);
            mdl_data[ch].push_back(d);
        end
        mdl_len[ch].push_back(len);
    endtask

    // Frame-level arbitration: each frame goes to the first channel at or after
    // the pointer that is enabled and has a frame waiting; truncation at MAXB.
    task automatic build_expected(input bit drop_ch0);
        logic [NCH-1:0] en;
        int ch, len, n;
        logic [63:0] d;
        en = '1;
        exp_trunc = 0;
        while (1) begin
            ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (mdl_rr + k) % NCH;
                if (ch < 0 && en[c] && mdl_len[c].size() > 0) ch = c;
            end
            if (ch < 0) break;
            len = mdl_len[ch].pop_front();
            n = (len > MAXB) ? MAXB : len;
            for (int b = 0; b < len; b++) begin
                d = mdl_data[ch].pop_front();
                if (b < n) exp_q.push_back('{ch, d, (b == n - 1), (len > MAXB && b == n - 1)});
            end
            if (len > MAXB) exp_trunc++;
            exp_cnt[ch] = (exp_cnt[ch] + 1) % (1 << CW);
            mdl_rr = (ch + 1) % NCH;
            if (drop_ch0 && ch == 0) en[0] = 1'b0;
        end
    endtask

    task automatic quiesce();
        for (int c = 0; c < NCH; c++) s_req[c] = '0;
        m_rsp.tready = 1'b0;
    endtask

    // mode 0: tready=1, mode 1: toggling, mode 2: random.
    task automatic run_traffic(input int mode, input bit gaps, input int en_drop_after);
        int  cyc = 0, quiet = 0, ch0_hs = 0, ovs_seen = 0;
        bit  toggle = 1'b1, exp_idle_next = 1'b0, exp_ovs_next = 1'b0, bad_rdy;
        got_q.delete();
        while (1) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (drv_data[c].size() > 0 && !(gaps && mid[c] && $urandom_range(0, 2) == 0)) begin
                    s_req[c].tvalid = 1'b1;
                    s_req[c].t.data = drv_data[c][0];
                    s_req[c].t.last = drv_last[c][0];
                    s_req[c].t.strb = '1;
                    s_req[c].t.keep = '1;
                    s_req[c].t.id   = IdWidth'(c);
                    s_req[c].t.dest = DestWidth'(c);
                    s_req[c].t.user = '0;
                end else begin
                    s_req[c] = '0;
                end
            end
            m_rsp.tready = (mode == 0) ? 1'b1 : (mode == 1) ? toggle : 1'($urandom_range(0, 1));
            toggle = ~toggle;
            #1;
            if (exp_idle_next) begin
                vectors++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after_last: busy_o=%b expected 0", busy);
                end
            end
            if (exp_ovs_next) begin
                vectors++;
                if (ovs !== 1'b1) begin
                    errors++;
                    $display("FAIL oversize_pulse: oversize_o=%b expected 1", ovs);
                end
            end
            exp_idle_next = 1'b0;
            exp_ovs_next  = 1'b0;
            if (ovs === 1'b1) ovs_seen++;
            bad_rdy = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (!(busy === 1'b1 && int'(grant) == c) && s_rsp[c].tready !== 1'b0) bad_rdy = 1'b1;
            end
            vectors++;
            if (bad_rdy) begin
                errors++;
                $display("FAIL tready_gating: busy=%b grant=%0d tready=%b%b", busy, grant,
                         s_rsp[1].tready, s_rsp[0].tready);
            end
            if (m_req.tvalid === 1'b1 && m_rsp.tready === 1'b1) begin
                got_q.push_back('{int'(grant), m_req.t.data, m_req.t.last, m_req.t.user[0]});
                if (m_req.t.last && !m_req.t.user[0]) exp_idle_next = 1'b1;
                if (m_req.t.user[0]) exp_ovs_next = 1'b1;
                quiet = 0;
            end else begin
                quiet++;
            end
            for (int c = 0; c < NCH; c++) begin
                if (s_req[c].tvalid === 1'b1 && s_rsp[c].tready === 1'b1) begin
                    mid[c] = !drv_last[c][0];
                    void'(drv_data[c].pop_front());
                    void'(drv_last[c].pop_front());
                    if (c == 0) begin
                        ch0_hs++;
                        if (ch0_hs == en_drop_after) chan_en[0] = 1'b0;
                    end
                end
            end
            cyc++;
            if (quiet >= 20 && busy === 1'b0) break;
            if (cyc > 4000) begin
                errors++;
                $display("FAIL traffic_timeout: %0d cycles without settling, expected idle", cyc);
                break;
            end
        end
        quiesce();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i].ch != exp_q[i].ch || got_q[i].data !== exp_q[i].data ||
                got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
                errors++;
                $display("FAIL beat[%0d]: got ch%0d %h last=%b user=%b expected ch%0d %h last=%b user=%b",
                         i, got_q[i].ch, got_q[i].data, got_q[i].last, got_q[i].user,
                         exp_q[i].ch, exp_q[i].data, exp_q[i].last, exp_q[i].user);
            end
        end
        exp_q.delete();
        vectors++;
        if (ovs_seen != exp_trunc) begin
            errors++;
            $display("FAIL oversize_count: got %0d pulses expected %0d", ovs_seen, exp_trunc);
        end
        for (int c = 0; c < NCH; c++) begin
            vectors++;
            if (int'(fcnt[c]) != exp_cnt[c]) begin
                errors++;
                $display("FAIL frame_cnt[%0d]: got %0d expected %0d", c, fcnt[c], exp_cnt[c]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (m_req.tvalid !== 1'b0 || busy !== 1'b0 || ovs !== 1'b0 || fcnt !== '0 ||
            grant !== 1'b0 || s_rsp[0].tready !== 1'b0 || s_rsp[1].tready !== 1'b0) begin
            errors++;
            $display("FAIL %s: tvalid=%b busy=%b ovs=%b fcnt=%h grant=%b tready=%b%b expected all 0",
                     tag, m_req.tvalid, busy, ovs, fcnt, grant, s_rsp[1].tready, s_rsp[0].tready);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        chan_en = '1;
        m_rsp.tready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            s_req[c] = '0;
            s_req[c].tvalid = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        quiesce();
        rst_n = 1'b1;
        mdl_rr = 0;
        for (int c = 0; c < NCH; c++) exp_cnt[c] = 0;
    endtask

    task automatic test_contention();
        for (int f = 0; f < 3; f++) begin
            load_frame(0, $urandom_range(1, 6));
            load_frame(1, $urandom_range(1, 6));
        end
        build_expected(1'b0);
        run_traffic(0, 1'b0, -1);
    endtask

    task automatic test_single();
        load_frame(0, 4);
        build_expected(1'b0);
        run_traffic(0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        load_frame(0, $urandom_range(5, 7));
        load_frame(1, $urandom_range(5, 7));
        load_frame(0, $urandom_range(5, 7));
        build_expected(1'b0);
        run_traffic(1, 1'b1, -1);
    endtask

    task automatic test_oversize();
        load_frame(0, 12);
        load_frame(1, 3);
        load_frame(1, MAXB);
        load_frame(0, MAXB + 1);
        build_expected(1'b0);
        run_traffic(0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            load_frame(0, $urandom_range(1, 12));
            load_frame(1, $urandom_range(1, 12));
        end
        build_expected(1'b0);
        run_traffic(2, 1'b1, -1);
    endtask

    task automatic test_enable();
        load_frame(0, 5);
        load_frame(0, 3);
        load_frame(1, 4);
        build_expected(1'b1);
        run_traffic(0, 1'b0, 2);
        vectors++;
        if (drv_data[0].size() != 3) begin
            errors++;
            $display("FAIL disabled_ch0_pending: got %0d beats left expected 3", drv_data[0].size());
        end
        chan_en = '1;
        build_expected(1'b0);
        run_traffic(0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_frame();
        int hs = 0, cyc = 0;
        for (int b = 0; b < 6; b++) begin
            drv_data[0].push_back({$urandom, $urandom});
            drv_last[0].push_back(b == 5);
        end
        while (hs < 3 && cyc < 200) begin
            @(negedge clk);
            s_req[0] = '0;
            s_req[0].tvalid = 1'b1;
            s_req[0].t.data = drv_data[0][0];
            s_req[0].t.last = drv_last[0][0];
            m_rsp.tready = 1'b1;
            #1;
            if (s_rsp[0].tready === 1'b1) begin
                void'(drv_data[0].pop_front());
                void'(drv_last[0].pop_front());
                hs++;
            end
            cyc++;
        end
        vectors++;
        if (hs != 3) begin
            errors++;
            $display("FAIL reset_setup: got %0d handshakes expected 3", hs);
        end
        @(negedge clk);
        rst_n = 1'b0;
        s_req[0].t.data = drv_data[0][0];
        @(negedge clk);
        #1;
        check_reset_outputs("reset_mid_frame");
        drv_data[0].delete();
        drv_last[0].delete();
        mid[0] = 1'b0;
        quiesce();
        @(negedge clk);
        rst_n = 1'b1;
        mdl_rr = 0;
        for (int c = 0; c < NCH; c++) exp_cnt[c] = 0;
    endtask

    task automatic test_counter_wrap();
        for (int f = 0; f < 5; f++) load_frame(1, $urandom_range(1, 4));
        build_expected(1'b0);
        run_traffic(0, 1'b0, -1);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) mid[c] = 1'b0;
        quiesce();
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_oversize();
        test_random();
        test_enable();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
